einstein_keyboard: RTL and testbench
====================================

# einstein_keyboard

PS/2-to-matrix keyboard front end for the Tatung Einstein core. It receives raw PS/2 frames from the host, decodes set-2 scancodes including the E0/F0/E1 prefixes, and maintains the 8×8 Einstein key matrix plus the SHIFT, CTRL and GRAPH lines. It answers row strobes from the PSG port A with active-low column data on PSG port B, and drives the `kb_down` level that the system logic turns into the keyboard interrupt.

## Interface
Parameters:
- `FILTER`, 8: number of consecutive identical samples required before a PS/2 clock level is accepted.
- `TIMEOUT`, 32000: idle cycles allowed between falling PS/2 clock edges inside a frame (1 ms at 32 MHz).

Ports:
- `clk_sys`  in  1  system clock, 32 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_kbd_clk`  in  1  raw PS/2 clock, asynchronous to `clk_sys`.
- `ps2_kbd_data`  in  1  raw PS/2 data, asynchronous to `clk_sys`.
- `kb_row`  in  8  active-low row select from PSG port A.
- `kb_col`  out  8  active-low column data to PSG port B.
- `kb_shift`, `kb_ctrl`, `kb_graph`  out  1 each  modifier lines, low while held.
- `kb_down`  out  1  high while any matrix key is held. Modifiers are excluded.
- `parity_err`  out  1  one-cycle pulse when a frame is rejected for bad parity. Only present with the parity-check feature enabled.

## Operation
- **Input conditioning.** Both PS/2 inputs pass through two synchronising flops.
  - The clock then goes through a saturating `FILTER`-sample glitch filter.
  - A receive bit is taken on the falling edge of the filtered clock.
- **Frame receiver.** A 4-bit bit counter runs 0..10 and the frame is start(0), 8 data bits LSB first, odd parity, stop(1).
  - Bit 0 sampled as 1: the frame is not started and the counter stays at 0.
  - Stop bit sampled as 0: the frame is discarded.
  - A valid frame produces a one-cycle `byte_valid` strobe with an 8-bit code.
- **Receiver timeout.** A 16-bit counter resets on every filtered falling edge.
  - If it reaches `TIMEOUT` while the bit counter is non-zero, the partial frame is discarded and the counter returns to 0.
  - The E0, F0 and skip flags are also cleared.
- **Decoder.** Prefix flags `ext` and `brk`, plus a 3-bit `skip` counter, are handled per received byte:
  - `E0` sets `ext`.
  - `F0` sets `brk`.
  - `E1` loads `skip` = 7. While `skip` is non-zero, each byte only decrements it; the Pause sequence is ignored.
  - `AA`, `FA`, `EE`, `FE`, `00` and `FF` are ignored and leave the flags untouched.
  - Any other byte is looked up with {`ext`, code}, the addressed bit is written with `~brk`, and `ext` and `brk` are cleared.
  - Codes that are not in the map only clear the flags.
- **Keymap.** The keymap is a case list inside the block, following the Einstein matrix chart. Fixed entries:
  - `1C` (A): row 3, col 1.
  - `29` (space): row 0, col 7.
  - `5A` (return): row 2, col 0.
  - E0 `75` (up): row 1, col 4.
  - `12` (left shift) and `59` (right shift): two separate shift bits.
  - `14` / E0 `14` (ctrl) and `11` (left alt): ctrl and graph.
- **Outputs.** The matrix is `mtx[7:0][7:0]`, with 1 meaning pressed.
  - `kb_col[c]` = ~OR over r of (`mtx[r][c]` & ~`kb_row[r]`). Several low rows are wire-ANDed. No ghosting is modelled.
  - `kb_shift` = ~(`lshift` | `rshift`).
  - `kb_down` = OR of all `mtx` bits.

## Timing
- **Reset values.** `reset` asynchronously clears the matrix, modifiers, flags and counters. Outputs on reset: `kb_col` = FF, `kb_shift` = `kb_ctrl` = `kb_graph` = 1, `kb_down` = 0, `parity_err` = 0.
- **Latency.**
  - `byte_valid` fires 1 cycle after the filtered falling edge of the stop bit.
  - The matrix updates on the next cycle.
  - `kb_col`, the modifiers and `kb_down` are registered and follow 1 cycle after that.
- **`kb_row` response.** A change on `kb_row` reaches `kb_col` after 1 cycle.
- **Simultaneous events.** If a matrix update and a `kb_row` change land in the same cycle, the next `kb_col` reflects both.
- **Edges.**
  - Press of an already-pressed key (typematic repeat) causes no change, so `kb_down` stays high.
  - Release of an unpressed key causes no change.
  - `kb_down` falls only when the last matrix key is released.
- **Reset mid-frame.** The partial frame is lost. The first frame after reset must start from a fresh start bit.

## Configuration
- `EINSTEIN_KB_PARITY_CHECK_EN` defined: the parity bit is checked. A frame failing odd parity is discarded, no decoder action occurs, and `parity_err` pulses for 1 cycle.
- Not defined: the parity bit is sampled but ignored, and `parity_err` is tied to 0.

## Test plan
- **Press A.** Send frame `1C`, then drive `kb_row` = F7. Expect `kb_col` = FD and `kb_down` = 1. Drive `kb_row` = FE: expect `kb_col` = FF.
- **Release A.** Send `F0 1C`. Expect `kb_down` = 0 and `kb_col` = FF for every `kb_row`.
- **Extended code and multi-row select.** Send E0 `75` and `29`, then drive `kb_row` = FC. Expect `kb_col` = 6F (cols 4 and 7 low).
- **Shift overlap.** Send `12`, `59`, then `F0 12`. Expect `kb_shift` = 0 throughout. Then send `F0 59`: expect `kb_shift` = 1, with `kb_down` = 0 the whole time.
- **Timeout.** Send 5 bits of a frame, then hold the PS/2 clock high for `TIMEOUT` + 10 cycles, then send a full `1C`. Expect only A pressed.
- **Pause and parity.** Send E1 `14 77 E1 F0 14 F0 77`, then `5A`. Expect only return pressed (row 2: `kb_col` = FE). With `EINSTEIN_KB_PARITY_CHECK_EN` defined, a `1C` frame with flipped parity gives a single `parity_err` pulse and no matrix change.

Source files
------------

// File: rtl/einstein_keyboard.sv
// einstein_keyboard: PS/2 set-2 to Einstein 8x8 matrix front end; `define EINSTEIN_KB_PARITY_CHECK_EN to reject bad-parity frames
module einstein_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 32000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  input  logic [7:0] kb_row,
  output logic [7:0] kb_col,
  output logic       kb_shift,
  output logic       kb_ctrl,
  output logic       kb_graph,
  output logic       kb_down,
  output logic       parity_err
);
  localparam int FW = $clog2(FILTER + 1);
  logic [1:0]    ck_s_q, dt_s_q;
  logic [FW-1:0] flt_cnt_q;
  logic          flt_q, fall, dat, tmo;
  logic [3:0]    bit_q;
  logic [7:0]    rx_q, code_q;
  logic          bv_q;
  logic [15:0]   to_q;
  logic          ext_q, brk_q;
  logic [2:0]    skip_q;
  logic [63:0]   mtx_q;
  logic [3:0]    mods_q;
  logic [7:0]    km, col_d, col_q;
  logic          kshift_q, kctrl_q, kgraph_q, down_q;
`ifdef EINSTEIN_KB_PARITY_CHECK_EN
  logic          par_q, perr_q;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  // {valid, modifier, index}: matrix index is row*8+col; modifiers 0 lshift, 1 rshift, 2 ctrl, 3 graph
  function automatic logic [7:0] keymap(input logic [8:0] k);
    case (k)
      9'h029: keymap = 8'h87; 9'h175: keymap = 8'h8C; 9'h172: keymap = 8'h8D; 9'h16B: keymap = 8'h8E;
      9'h174: keymap = 8'h8F; 9'h05A: keymap = 8'h90; 9'h066: keymap = 8'h91; 9'h00D: keymap = 8'h92;
      9'h076: keymap = 8'h93; 9'h01C: keymap = 8'h99; 9'h032: keymap = 8'h9A; 9'h021: keymap = 8'h9B;
      9'h023: keymap = 8'h9C; 9'h024: keymap = 8'h9D; 9'h02B: keymap = 8'h9E; 9'h034: keymap = 8'h9F;
      9'h033: keymap = 8'hA0; 9'h043: keymap = 8'hA1; 9'h03B: keymap = 8'hA2; 9'h042: keymap = 8'hA3;
      9'h04B: keymap = 8'hA4; 9'h03A: keymap = 8'hA5; 9'h031: keymap = 8'hA6; 9'h044: keymap = 8'hA7;
      9'h04D: keymap = 8'hA8; 9'h015: keymap = 8'hA9; 9'h02D: keymap = 8'hAA; 9'h01B: keymap = 8'hAB;
      9'h02C: keymap = 8'hAC; 9'h03C: keymap = 8'hAD; 9'h02A: keymap = 8'hAE; 9'h01D: keymap = 8'hAF;
      9'h022: keymap = 8'hB0; 9'h035: keymap = 8'hB1; 9'h01A: keymap = 8'hB2; 9'h045: keymap = 8'hB8;
      9'h016: keymap = 8'hB9; 9'h01E: keymap = 8'hBA; 9'h026: keymap = 8'hBB; 9'h025: keymap = 8'hBC;
      9'h02E: keymap = 8'hBD; 9'h036: keymap = 8'hBE; 9'h03D: keymap = 8'hBF;
      9'h012: keymap = 8'hC0; 9'h059: keymap = 8'hC1; 9'h014: keymap = 8'hC2; 9'h114: keymap = 8'hC2;
      9'h011: keymap = 8'hC3;
      default: keymap = 8'h00;
    endcase
  endfunction
  assign km   = keymap({ext_q, code_q});
  assign dat  = dt_s_q[1];
  assign fall = flt_q & ~ck_s_q[1] & (flt_cnt_q == FW'(FILTER - 1));
  assign tmo  = ~fall & (to_q == 16'(TIMEOUT)) & (bit_q != 4'd0);
  // Synchronise both lines and accept a new clock level only after FILTER agreeing samples
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ck_s_q    <= 2'b11;
      dt_s_q    <= 2'b11;
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      ck_s_q <= {ck_s_q[0], ps2_kbd_clk};
      dt_s_q <= {dt_s_q[0], ps2_kbd_data};
      if (ck_s_q[1] == flt_q) flt_cnt_q <= '0;
      else if (flt_cnt_q == FW'(FILTER - 1)) begin
        flt_q     <= ck_s_q[1];
        flt_cnt_q <= '0;
      end else flt_cnt_q <= flt_cnt_q + FW'(1);
    end
  end
  // Frame receiver with inter-edge timeout; the data bit is taken as the filtered clock falls
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_q  <= 4'd0;
      rx_q   <= 8'd0;
      code_q <= 8'd0;
      bv_q   <= 1'b0;
      to_q   <= 16'd0;
`ifdef EINSTEIN_KB_PARITY_CHECK_EN
      par_q  <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      bv_q <= 1'b0;
`ifdef EINSTEIN_KB_PARITY_CHECK_EN
      perr_q <= 1'b0;
`endif
      if (fall) begin
        to_q <= 16'd0;
        if (bit_q == 4'd0) bit_q <= {3'b0, ~dat};
        else if (bit_q <= 4'd8) begin
          rx_q  <= {dat, rx_q[7:1]};
          bit_q <= bit_q + 4'd1;
        end else if (bit_q == 4'd9) begin
`ifdef EINSTEIN_KB_PARITY_CHECK_EN
          par_q <= dat;
`endif
          bit_q <= 4'd10;
        end else begin
          bit_q  <= 4'd0;
          code_q <= rx_q;
`ifdef EINSTEIN_KB_PARITY_CHECK_EN
          bv_q   <= dat & ^{par_q, rx_q};
          perr_q <= dat & ~^{par_q, rx_q};
`else
          bv_q   <= dat;
`endif
        end
      end else begin
        if (to_q != 16'(TIMEOUT)) to_q <= to_q + 16'd1;
        if (tmo) bit_q <= 4'd0;
      end
    end
  end
  // Scancode decoder: prefix flags, Pause skipping, matrix and modifier updates
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= 3'd0;
      mtx_q  <= 64'd0;
      mods_q <= 4'd0;
    end else if (tmo) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= 3'd0;
    end else if (bv_q) begin
      if (skip_q != 3'd0) skip_q <= skip_q - 3'd1;
      else if (code_q == 8'hE1) skip_q <= 3'd7;
      else if (code_q == 8'hE0) ext_q <= 1'b1;
      else if (code_q == 8'hF0) brk_q <= 1'b1;
      else if (!(code_q inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (km[7] & km[6]) mods_q[km[1:0]] <= ~brk_q;
        if (km[7] & ~km[6]) mtx_q[km[5:0]] <= ~brk_q;
      end
    end
  end
  // Wire-AND of the pressed keys in every selected row
  always_comb begin
    col_d = 8'hFF;
    for (int r = 0; r < 8; r++) col_d = kb_row[r] ? col_d : col_d & ~mtx_q[r*8 +: 8];
  end
  // Registered PSG-facing outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      col_q    <= 8'hFF;
      kshift_q <= 1'b1;
      kctrl_q  <= 1'b1;
      kgraph_q <= 1'b1;
      down_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      kshift_q <= ~(mods_q[0] | mods_q[1]);
      kctrl_q  <= ~mods_q[2];
      kgraph_q <= ~mods_q[3];
      down_q   <= |mtx_q;
    end
  end
  assign kb_col   = col_q;
  assign kb_shift = kshift_q;
  assign kb_ctrl  = kctrl_q;
  assign kb_graph = kgraph_q;
  assign kb_down  = down_q;
endmodule

// File: tb/tb_einstein_keyboard.sv
// tb_einstein_keyboard: directed table of PS/2 frames against the Einstein matrix outputs
module tb_einstein_keyboard;
  typedef struct {
    logic       snd;
    logic [7:0] code;
    logic [7:0] row;
    logic [7:0] col;
    logic       dn;
    logic       sh;
    logic       ct;
    logic       gr;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, pc = 1'b1, pd = 1'b1;
  logic [7:0] row = 8'hFF;
  logic [7:0] col;
  logic sh, ct, gr, dn, pe;
  int errs = 0, checks = 0, pe_cnt = 0, p0;
  vec_t tv[$];
  always #5 clk = ~clk;
  always @(negedge clk) if (pe === 1'b1) pe_cnt++;
  einstein_keyboard #(.FILTER(8), .TIMEOUT(500)) dut (
    .clk_sys(clk), .reset(rst), .ps2_kbd_clk(pc), .ps2_kbd_data(pd), .kb_row(row),
    .kb_col(col), .kb_shift(sh), .kb_ctrl(ct), .kb_graph(gr), .kb_down(dn), .parity_err(pe)
  );
  function automatic vec_t mk(logic s, logic [7:0] c, logic [7:0] r, logic [7:0] k, logic d, logic h, logic t, logic g);
    vec_t v;
    v.snd = s; v.code = c; v.row = r; v.col = k; v.dn = d; v.sh = h; v.ct = t; v.gr = g;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic ps2_bit(input logic b);
    pd = b;
    cyc(10);
    pc = 1'b0;
    cyc(20);
    pc = 1'b1;
    cyc(10);
  endtask
  task automatic sendp(input logic [7:0] b, input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad);
    ps2_bit(1'b1);
    cyc(30);
  endtask
  task automatic send(input logic [7:0] b);
    sendp(b, 1'b0);
  endtask
  task automatic partial();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
  endtask
  task automatic setrow(input logic [7:0] r);
    @(negedge clk);
    row = r;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(0, 8'h00, 8'hFE, 8'hFF, 1, 1, 1, 1));
    tv.push_back(mk(0, 8'h00, 8'hF0, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hE0, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h75, 8'hFD, 8'hEF, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h29, 8'hFC, 8'h6F, 1, 1, 1, 1));
    tv.push_back(mk(0, 8'h00, 8'hFE, 8'h7F, 1, 1, 1, 1));
    tv.push_back(mk(0, 8'h00, 8'hFD, 8'hEF, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hE0, 8'hFC, 8'h6F, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'hFC, 8'h6F, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h75, 8'hFC, 8'h7F, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'hFC, 8'h7F, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h29, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h12, 8'h00, 8'hFF, 0, 0, 1, 1));
    tv.push_back(mk(1, 8'h59, 8'h00, 8'hFF, 0, 0, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFF, 0, 0, 1, 1));
    tv.push_back(mk(1, 8'h12, 8'h00, 8'hFF, 0, 0, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFF, 0, 0, 1, 1));
    tv.push_back(mk(1, 8'h59, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h14, 8'h00, 8'hFF, 0, 1, 0, 1));
    tv.push_back(mk(1, 8'h11, 8'h00, 8'hFF, 0, 1, 0, 0));
    tv.push_back(mk(1, 8'hE0, 8'h00, 8'hFF, 0, 1, 0, 0));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFF, 0, 1, 0, 0));
    tv.push_back(mk(1, 8'h14, 8'h00, 8'hFF, 0, 1, 1, 0));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFF, 0, 1, 1, 0));
    tv.push_back(mk(1, 8'h11, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hAA, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hFA, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h0E, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hE0, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'hF7, 8'hFD, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h1C, 8'hF7, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hE1, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h14, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h77, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hE1, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h14, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h77, 8'h00, 8'hFF, 0, 1, 1, 1));
    tv.push_back(mk(1, 8'h5A, 8'hFB, 8'hFE, 1, 1, 1, 1));
    tv.push_back(mk(0, 8'h00, 8'h00, 8'hFE, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'hF0, 8'h00, 8'hFE, 1, 1, 1, 1));
    tv.push_back(mk(1, 8'h5A, 8'h00, 8'hFF, 0, 1, 1, 1));
    row = 8'h00;
    cyc(5);
    @(negedge clk);
    chk("reset col", col, 8'hFF);
    chk("reset down", {7'b0, dn}, 8'h00);
    chk("reset mods", {5'b0, sh, ct, gr}, 8'h07);
    chk("reset perr", {7'b0, pe}, 8'h00);
    rst = 1'b0;
    cyc(5);
    foreach (tv[i]) begin
      if (tv[i].snd) send(tv[i].code);
      setrow(tv[i].row);
      chk($sformatf("v%0d col", i), col, tv[i].col);
      chk($sformatf("v%0d down", i), {7'b0, dn}, {7'b0, tv[i].dn});
      chk($sformatf("v%0d mods", i), {5'b0, sh, ct, gr}, {5'b0, tv[i].sh, tv[i].ct, tv[i].gr});
    end
    send(8'h1C);
    setrow(8'hFE);
    @(negedge clk);
    row = 8'hF7;
    #1;
    chk("row lat old", col, 8'hFF);
    @(negedge clk);
    chk("row lat new", col, 8'hFD);
    send(8'hF0);
    send(8'h1C);
    setrow(8'h00);
    chk("pre-timeout down", {7'b0, dn}, 8'h00);
    send(8'hF0);
    partial();
    cyc(510);
    send(8'h1C);
    setrow(8'hF7);
    chk("timeout row3", col, 8'hFD);
    setrow(8'h00);
    chk("timeout all rows", col, 8'hFD);
    chk("timeout down", {7'b0, dn}, 8'h01);
    send(8'hF0);
    send(8'h1C);
    setrow(8'h00);
    chk("timeout release", {7'b0, dn}, 8'h00);
    send(8'h1C);
    send(8'h12);
    partial();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset col", col, 8'hFF);
    chk("midreset down", {7'b0, dn}, 8'h00);
    chk("midreset shift", {7'b0, sh}, 8'h01);
    rst = 1'b0;
    cyc(50);
    send(8'h1C);
    setrow(8'hF7);
    chk("post-reset press", col, 8'hFD);
    send(8'hF0);
    send(8'h1C);
    setrow(8'h00);
    chk("post-reset release", {7'b0, dn}, 8'h00);
    p0 = pe_cnt;
`ifdef EINSTEIN_KB_PARITY_CHECK_EN
    sendp(8'h1C, 1'b1);
    setrow(8'hF7);
    chk("bad parity pulses", 8'(pe_cnt - p0), 8'd1);
    chk("bad parity col", col, 8'hFF);
    chk("bad parity down", {7'b0, dn}, 8'h00);
`else
    sendp(8'h1C, 1'b1);
    setrow(8'hF7);
    chk("parity ignored pulses", 8'(pe_cnt - p0), 8'd0);
    chk("parity ignored col", col, 8'hFD);
    send(8'hF0);
    send(8'h1C);
    setrow(8'h00);
    chk("parity ignored release", {7'b0, dn}, 8'h00);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
